// File: rtl/parity_reg_arbiter.sv
// Round-robin arbiter sharing one parity register between NREQ requesters,
// answering through a valid/ready response channel. Optional macro: PARITY_CHECK_EN.
module parity_reg_arbiter #(
    parameter int width = 8,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*width-1:0] data_in,
    input  logic [NREQ-1:0]       par_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [width-1:0]      q,
    output logic                  parity,
    output logic                  resp_err,
    output logic                  err_sticky,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [width-1:0] data_q, data_d;
    logic [IDW-1:0]   win_s;
    logic             found_s;
    int               idx_s;
    logic [width-1:0] slice_s;
    logic             par_sel_s;

    // Round-robin search starting after last_id, wrapping modulo NREQ
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s   = (int'(last_id_q) + k) % NREQ;
            win_s   = (!found_s && req[idx_s]) ? IDW'(idx_s) : win_s;
            found_s = found_s | req[idx_s];
        end
    end

    // Data and expected-parity mux for the granted requester
    always_comb begin
        slice_s   = '0;
        par_sel_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            slice_s   = (id_q == IDW'(i)) ? data_in[i*width +: width] : slice_s;
            par_sel_s = (id_q == IDW'(i)) ? par_in[i] : par_sel_s;
        end
    end

    // FSM next state and datapath register enable
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = LOAD;
                    id_d    = win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                data_d  = slice_s;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    last_id_d = id_q;
                    state_d   = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, id and data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            last_id_q <= LAST_RST;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            data_q    <= data_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_cap_q;
    logic err_sticky_q;
    logic mismatch_s;

    assign mismatch_s = (state_q == RESP) && ((^data_q) != par_cap_q);

    // Capture expected parity in LOAD; latch any mismatch until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            par_cap_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            par_cap_q    <= (state_q == LOAD) ? par_sel_s : par_cap_q;
            err_sticky_q <= err_sticky_q | mismatch_s;
        end
    end

    assign resp_err   = mismatch_s;
    assign err_sticky = err_sticky_q;
`else
    logic unused_par_s;
    assign unused_par_s = par_sel_s;
    assign resp_err     = 1'b0;
    assign err_sticky   = 1'b0;
`endif

    // One-hot grant decoded from LOAD state
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (state_q == LOAD) && (id_q == IDW'(i));
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_id    = resp_valid ? id_q : '0;
    assign q          = data_q;
    assign parity     = ^data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_reg_arbiter.sv
// Directed self-checking bench for parity_reg_arbiter (NREQ=2, width=8).
module tb_parity_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] data_in;
    logic [1:0]  par_in;
    logic [1:0]  gnt;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [7:0]  q;
    logic        parity;
    logic        resp_err;
    logic        err_sticky;
    logic        busy;

    int passed = 0;
    int total  = 0;

`ifdef PARITY_CHECK_EN
    localparam bit PCE = 1'b1;
`else
    localparam bit PCE = 1'b0;
`endif

    parity_reg_arbiter #(.width(8), .NREQ(2)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .par_in(par_in),
        .gnt(gnt), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .q(q), .parity(parity), .resp_err(resp_err), .err_sticky(err_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req        = 2'b00;
        data_in    = {8'hA5, 8'h3C};
        par_in     = 2'b00;
        resp_ready = 1'b1;
        step();
        step();
        // Reset state
        check("rst_q", 32'(q), 32'd0);
        check("rst_parity", 32'(parity), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        reset = 1'b0;
        step();
        check_idle("idle_noreq");

        // Round-robin alternation
        req = 2'b11;
        step();
        check("rr1_gnt", 32'(gnt), 32'h1);
        check("rr1_busy", 32'(busy), 32'd1);
        check("rr1_valid", 32'(resp_valid), 32'd0);
        step();
        check("rr1_valid_r", 32'(resp_valid), 32'd1);
        check("rr1_id", 32'(resp_id), 32'd0);
        check("rr1_q", 32'(q), 32'h3C);
        check("rr1_par", 32'(parity), 32'd0);
        check("rr1_gnt_r", 32'(gnt), 32'd0);
        step();
        check_idle("rr1_done");
        step();
        check("rr2_gnt", 32'(gnt), 32'h2);
        step();
        check("rr2_id", 32'(resp_id), 32'd1);
        check("rr2_q", 32'(q), 32'hA5);
        check("rr2_par", 32'(parity), 32'd0);
        step();
        check("rr2_q_hold", 32'(q), 32'hA5);
        check_idle("rr2_done");
        step();
        check("rr3_gnt", 32'(gnt), 32'h1);

        // Backpressure
        resp_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_q", 32'(q), 32'h3C);
            check("bp_id", 32'(resp_id), 32'd0);
            check("bp_gnt", 32'(gnt), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            step();
        end
        resp_ready = 1'b1;
        check("bp_last_valid", 32'(resp_valid), 32'd1);
        step();
        check_idle("bp_done");

        // Single requester 1, then requester 0
        req     = 2'b10;
        data_in = {8'h07, 8'h3C};
        step();
        check("sr_gnt", 32'(gnt), 32'h2);
        step();
        check("sr_id", 32'(resp_id), 32'd1);
        check("sr_q", 32'(q), 32'h07);
        check("sr_par", 32'(parity), 32'd1);
        req = 2'b01;
        step();
        check_idle("sr_done");
        step();
        check("sr_next_gnt", 32'(gnt), 32'h1);
        step();
        check("sr_next_q", 32'(q), 32'h3C);
        step();

        // Reset mid-transaction (last_id=0, so requester 1 wins first)
        req = 2'b11;
        step();
        check("rm_load_gnt", 32'(gnt), 32'h2);
        reset = 1'b1;
        step();
        check_idle("rm_rst");
        check("rm_q", 32'(q), 32'd0);
        check("rm_par", 32'(parity), 32'd0);
        check("rm_sticky", 32'(err_sticky), 32'd0);
        reset = 1'b0;
        step();
        check("rm_first_gnt", 32'(gnt), 32'h1);
        step();
        check("rm_q2", 32'(q), 32'h3C);
        step();

        // Parity check: 8'h01 has parity 1, expected 0
        req     = 2'b01;
        data_in = {8'hA5, 8'h01};
        par_in  = 2'b00;
        step();
        check("pc_gnt", 32'(gnt), 32'h1);
        check("pc_err_load", 32'(resp_err), 32'd0);
        step();
        check("pc_q", 32'(q), 32'h01);
        check("pc_par", 32'(parity), 32'd1);
        check("pc_err", 32'(resp_err), 32'(PCE));
        req = 2'b00;
        step();
        check("pc_err_idle", 32'(resp_err), 32'd0);
        check("pc_sticky", 32'(err_sticky), 32'(PCE));
        // Good transaction keeps sticky set
        req     = 2'b01;
        data_in = {8'hA5, 8'h3C};
        step();
        step();
        check("pc_good_q", 32'(q), 32'h3C);
        check("pc_good_err", 32'(resp_err), 32'd0);
        check("pc_good_sticky", 32'(err_sticky), 32'(PCE));
        req   = 2'b00;
        reset = 1'b1;
        step();
        check("pc_rst_sticky", 32'(err_sticky), 32'd0);
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
